// File: rtl/atm_input_pkg.sv
// Shared definitions for the CryptoATM keypad input path: ASCII key codes,
// entry status codes, collector state encoding and the key class record.
package atm_input_pkg;

    localparam logic [7:0] ASC_0   = 8'h30;
    localparam logic [7:0] ASC_9   = 8'h39;
    localparam logic [7:0] ASC_CR  = 8'h0D;
    localparam logic [7:0] ASC_BS  = 8'h08;
    localparam logic [7:0] ASC_ESC = 8'h1B;

    localparam logic [3:0] ST_OK        = 4'd0;
    localparam logic [3:0] ST_TOO_SHORT = 4'd1;
    localparam logic [3:0] ST_OVERFLOW  = 4'd2;
    localparam logic [3:0] ST_BAD_CHAR  = 4'd3;
    localparam logic [3:0] ST_CANCEL    = 4'd4;
    localparam logic [3:0] ST_TIMEOUT   = 4'd5;

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    // One-hot classification of a received key byte.
    typedef struct packed {
        logic digit;
        logic enter;
        logic bksp;
        logic esc;
        logic other;
    } key_class_t;

    // Width of a field selector; a single-field bank still needs one bit.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/atm_keypad_entry_if.sv
// Handshake/bus signals between the ATM control FSM (master) and the
// keypad entry collector (slave).
interface atm_keypad_entry_if #(
    parameter int MAX_DIGITS = 4,
    parameter int NUM_FIELDS = 4
);
    import atm_input_pkg::*;

    localparam int VAL_W = 4 * MAX_DIGITS;
    localparam int FS_W  = sel_width(NUM_FIELDS);
    localparam int LEN_W = $clog2(MAX_DIGITS + 1);

    logic              start;
    logic [FS_W-1:0]   field_sel;
    logic              key_valid;
    logic [7:0]        key_code;
    logic              busy;
    logic [LEN_W-1:0]  cur_len;
    logic [VAL_W-1:0]  cur_value;
    logic              done;
    logic [3:0]        status_code_out;
    logic [FS_W-1:0]   field_id_out;
    logic [FS_W-1:0]   rd_sel;
    logic [VAL_W-1:0]  rd_value;
    logic              rd_valid;

    modport master (
        output start, field_sel, key_valid, key_code, rd_sel,
        input  busy, cur_len, cur_value, done, status_code_out, field_id_out,
               rd_value, rd_valid
    );

    modport slave (
        input  start, field_sel, key_valid, key_code, rd_sel,
        output busy, cur_len, cur_value, done, status_code_out, field_id_out,
               rd_value, rd_valid
    );

endinterface

// File: rtl/atm_key_classify.sv
// Combinational key decoder: sorts an ASCII byte into digit / enter /
// backspace / escape / other and extracts the BCD digit value.
module atm_key_classify
    import atm_input_pkg::*;
(
    input  logic [7:0]  key_code,
    output key_class_t  key_class,
    output logic [3:0]  digit_val
);

    // Exactly one class bit is set for every possible byte.
    always_comb begin
        key_class = '0;
        digit_val = key_code[3:0];
        if (key_code >= ASC_0 && key_code <= ASC_9) begin
            key_class.digit = 1'b1;
        end else if (key_code == ASC_CR) begin
            key_class.enter = 1'b1;
        end else if (key_code == ASC_BS) begin
            key_class.bksp = 1'b1;
        end else if (key_code == ASC_ESC) begin
            key_class.esc = 1'b1;
        end else begin
            key_class.other = 1'b1;
        end
    end

endmodule

// File: rtl/atm_keypad_entry.sv
// Keypad entry collector: accumulates decimal keys into a packed-BCD field,
// handles backspace/cancel/length checks and commits finished entries into
// a bank of NUM_FIELDS registers read back by the ATM control FSM.
// Optional inactivity timeout enabled by defining KEYPAD_TIMEOUT_EN.
module atm_keypad_entry
    import atm_input_pkg::*;
#(
    parameter int MAX_DIGITS  = 4,
    parameter int MIN_DIGITS  = 4,
    parameter int NUM_FIELDS  = 4,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic               clk,
    input  logic               rst_n,
    atm_keypad_entry_if.slave  bus
);

    localparam int VAL_W = 4 * MAX_DIGITS;
    localparam int FS_W  = sel_width(NUM_FIELDS);
    localparam int LEN_W = $clog2(MAX_DIGITS + 1);
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_DIGITS);
    localparam logic [LEN_W-1:0] LEN_MIN = LEN_W'(MIN_DIGITS);

    state_t             state;
    logic [FS_W-1:0]    field;
    logic [LEN_W-1:0]   cur_len;
    logic [VAL_W-1:0]   cur_value;
    logic               done;
    logic [3:0]         status;
    logic [FS_W-1:0]    field_id;
    logic [VAL_W-1:0]   bank [NUM_FIELDS];
    logic [NUM_FIELDS-1:0] valid;

    key_class_t         kc;
    logic [3:0]         digit_val;
    logic               timeout_hit;

    atm_key_classify u_classify (
        .key_code  (bus.key_code),
        .key_class (kc),
        .digit_val (digit_val)
    );

`ifdef KEYPAD_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYC);

    logic [TO_W-1:0] idle_cnt;

    // Inactivity counter: restarts on start or any key, counts idle COLLECT cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt <= '0;
        end else if (bus.start || bus.key_valid || state != COLLECT) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + TO_W'(1);
        end
    end

    // Expire on the edge where the counter would reach the limit.
    assign timeout_hit = (state == COLLECT) && ((idle_cnt + TO_W'(1)) == TO_LIMIT);
`else
    // Without the feature an entry waits indefinitely; TIMEOUT_CYC has no effect.
    assign timeout_hit = (TIMEOUT_CYC < 0);
`endif

    // Entry FSM, field bank and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            field     <= '0;
            cur_len   <= '0;
            cur_value <= '0;
            done      <= 1'b0;
            status    <= ST_OK;
            field_id  <= '0;
            valid     <= '0;
            for (int i = 0; i < NUM_FIELDS; i++) begin
                bank[i] <= '0;
            end
        end else begin
            done <= 1'b0;
            if (bus.start) begin
                state     <= COLLECT;
                field     <= bus.field_sel;
                cur_len   <= '0;
                cur_value <= '0;
                status    <= ST_OK;
            end else if (state == COLLECT) begin
                if (bus.key_valid) begin
                    if (kc.digit) begin
                        if (cur_len < LEN_MAX) begin
                            cur_value <= (cur_value << 4) | VAL_W'(digit_val);
                            cur_len   <= cur_len + LEN_W'(1);
                        end else begin
                            status <= ST_OVERFLOW;
                        end
                    end else if (kc.bksp) begin
                        if (cur_len != '0) begin
                            cur_value <= cur_value >> 4;
                            cur_len   <= cur_len - LEN_W'(1);
                        end
                    end else if (kc.enter) begin
                        done     <= 1'b1;
                        field_id <= field;
                        state    <= IDLE;
                        if (cur_len >= LEN_MIN) begin
                            bank[field]  <= cur_value;
                            valid[field] <= 1'b1;
                            status       <= ST_OK;
                        end else begin
                            status <= ST_TOO_SHORT;
                        end
                    end else if (kc.esc) begin
                        done     <= 1'b1;
                        field_id <= field;
                        state    <= IDLE;
                        status   <= ST_CANCEL;
                    end else if (kc.other) begin
                        status <= ST_BAD_CHAR;
                    end
                end else if (timeout_hit) begin
                    done     <= 1'b1;
                    field_id <= field;
                    state    <= IDLE;
                    status   <= ST_TIMEOUT;
                end
            end
        end
    end

    // Combinational bank read; out-of-range selects read as empty.
    always_comb begin
        bus.rd_value = '0;
        bus.rd_valid = 1'b0;
        if (int'(bus.rd_sel) < NUM_FIELDS) begin
            bus.rd_value = bank[bus.rd_sel];
            bus.rd_valid = valid[bus.rd_sel];
        end
    end

    assign bus.busy            = (state == COLLECT);
    assign bus.cur_len         = cur_len;
    assign bus.cur_value       = cur_value;
    assign bus.done            = done;
    assign bus.status_code_out = status;
    assign bus.field_id_out    = field_id;

endmodule

// File: tb/tb_atm_keypad_entry.sv
// Self-checking bench for atm_keypad_entry: directed key sequences, with
// every terminating entry predicted into a scoreboard queue that a done
// monitor pops and compares. Timeout steps run when KEYPAD_TIMEOUT_EN is set.
module tb_atm_keypad_entry;
    import atm_input_pkg::*;

    typedef struct packed {
        logic [3:0] status;
        logic [1:0] field;
    } exp_t;

    logic clk;
    logic rst_n;
    int   tests_run;
    int   tests_failed;
    exp_t exp_q[$];
    exp_t exp_head;

    atm_keypad_entry_if #(.MAX_DIGITS(4), .NUM_FIELDS(4)) bus ();

    atm_keypad_entry #(
        .MAX_DIGITS  (4),
        .MIN_DIGITS  (4),
        .NUM_FIELDS  (4),
        .TIMEOUT_CYC (20)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so the run always ends.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Every done pulse must match the oldest predicted termination.
    always @(negedge clk) begin
        if (bus.done) begin
            if (exp_q.size() == 0) begin
                check_output("unexpected_done", 32'(bus.done), 32'd0);
            end else begin
                exp_head = exp_q.pop_front();
                check_output("done_status", 32'(bus.status_code_out), 32'(exp_head.status));
                check_output("done_field", 32'(bus.field_id_out), 32'(exp_head.field));
            end
        end
    end

    task automatic do_start(input logic [1:0] sel);
        bus.start     = 1'b1;
        bus.field_sel = sel;
        @(negedge clk);
        bus.start     = 1'b0;
    endtask

    task automatic apply_stimulus(input logic [7:0] code);
        bus.key_valid = 1'b1;
        bus.key_code  = code;
        @(negedge clk);
        bus.key_valid = 1'b0;
        bus.key_code  = 8'h00;
    endtask

    task automatic type_str(input string s);
        for (int i = 0; i < s.len(); i++) begin
            apply_stimulus(s[i]);
        end
    endtask

    task automatic start_with_key(input logic [1:0] sel, input logic [7:0] code);
        bus.start     = 1'b1;
        bus.field_sel = sel;
        bus.key_valid = 1'b1;
        bus.key_code  = code;
        @(negedge clk);
        bus.start     = 1'b0;
        bus.key_valid = 1'b0;
        bus.key_code  = 8'h00;
    endtask

    task automatic read_check(input string tag, input logic [1:0] sel,
                              input logic [15:0] value, input logic ok);
        bus.rd_sel = sel;
        #1;
        check_output({tag, "_value"}, 32'(bus.rd_value), 32'(value));
        check_output({tag, "_valid"}, 32'(bus.rd_valid), 32'(ok));
    endtask

    function automatic exp_t mk(input logic [3:0] st, input logic [1:0] f);
        mk.status = st;
        mk.field  = f;
    endfunction

    initial begin
        tests_run     = 0;
        tests_failed  = 0;
        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.field_sel = '0;
        bus.key_valid = 1'b0;
        bus.key_code  = 8'h00;
        bus.rd_sel    = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check_output("rst_busy", 32'(bus.busy), 32'd0);
        check_output("rst_done", 32'(bus.done), 32'd0);
        check_output("rst_status", 32'(bus.status_code_out), 32'(ST_OK));
        check_output("rst_len", 32'(bus.cur_len), 32'd0);
        check_output("rst_value", 32'(bus.cur_value), 32'd0);
        check_output("rst_field_id", 32'(bus.field_id_out), 32'd0);
        for (int f = 0; f < 4; f++) read_check("rst_bank", 2'(f), 16'h0000, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Digit entry and commit into field 1
        do_start(2'd1);
        check_output("start_busy", 32'(bus.busy), 32'd1);
        check_output("start_len", 32'(bus.cur_len), 32'd0);
        type_str("0274");
        check_output("entry_value", 32'(bus.cur_value), 32'h0274);
        check_output("entry_len", 32'(bus.cur_len), 32'd4);
        bus.rd_sel = 2'd1;
        exp_q.push_back(mk(ST_OK, 2'd1));
        apply_stimulus(ASC_CR);
        check_output("commit_busy", 32'(bus.busy), 32'd0);
        check_output("commit_rd_same_cycle", 32'(bus.rd_value), 32'h0274);
        read_check("commit_f1", 2'd1, 16'h0274, 1'b1);

        // Short entry, then backspace correction into field 0
        do_start(2'd0);
        type_str("027");
        exp_q.push_back(mk(ST_TOO_SHORT, 2'd0));
        apply_stimulus(ASC_CR);
        read_check("short_f0", 2'd0, 16'h0000, 1'b0);
        do_start(2'd0);
        type_str("0275");
        apply_stimulus(ASC_BS);
        check_output("bs_value", 32'(bus.cur_value), 32'h0027);
        check_output("bs_len", 32'(bus.cur_len), 32'd3);
        type_str("4");
        exp_q.push_back(mk(ST_OK, 2'd0));
        apply_stimulus(ASC_CR);
        read_check("bs_f0", 2'd0, 16'h0274, 1'b1);

        // Overflow and bad character into field 2
        do_start(2'd2);
        type_str("12345");
        check_output("ovf_value", 32'(bus.cur_value), 32'h1234);
        check_output("ovf_status", 32'(bus.status_code_out), 32'(ST_OVERFLOW));
        apply_stimulus(8'h40);
        check_output("bad_status", 32'(bus.status_code_out), 32'(ST_BAD_CHAR));
        check_output("bad_busy", 32'(bus.busy), 32'd1);
        exp_q.push_back(mk(ST_OK, 2'd2));
        apply_stimulus(ASC_CR);
        read_check("ovf_f2", 2'd2, 16'h1234, 1'b1);

        // Backspace on empty entry, then cancel on field 3
        do_start(2'd3);
        apply_stimulus(ASC_BS);
        check_output("bs_empty_len", 32'(bus.cur_len), 32'd0);
        check_output("bs_empty_status", 32'(bus.status_code_out), 32'(ST_OK));
        check_output("bs_empty_busy", 32'(bus.busy), 32'd1);
        type_str("99");
        exp_q.push_back(mk(ST_CANCEL, 2'd3));
        apply_stimulus(ASC_ESC);
        check_output("cancel_busy", 32'(bus.busy), 32'd0);
        read_check("cancel_f3", 2'd3, 16'h0000, 1'b0);
        read_check("cancel_f1", 2'd1, 16'h0274, 1'b1);
        apply_stimulus("7");
        check_output("idle_hold_value", 32'(bus.cur_value), 32'h0099);
        check_output("idle_hold_len", 32'(bus.cur_len), 32'd2);
        check_output("idle_sticky_status", 32'(bus.status_code_out), 32'(ST_CANCEL));

        // Restart mid-entry with a simultaneous key, then commit to new field
        do_start(2'd3);
        check_output("start_clears_status", 32'(bus.status_code_out), 32'(ST_OK));
        type_str("55");
        start_with_key(2'd0, "8");
        check_output("restart_len", 32'(bus.cur_len), 32'd0);
        check_output("restart_value", 32'(bus.cur_value), 32'h0000);
        check_output("restart_busy", 32'(bus.busy), 32'd1);
        type_str("1234");
        exp_q.push_back(mk(ST_OK, 2'd0));
        apply_stimulus(ASC_CR);
        read_check("restart_f0", 2'd0, 16'h1234, 1'b1);

        // Start in IDLE with a key in the same cycle: key dropped
        start_with_key(2'd3, "9");
        check_output("idle_start_len", 32'(bus.cur_len), 32'd0);
        check_output("idle_start_busy", 32'(bus.busy), 32'd1);
        exp_q.push_back(mk(ST_CANCEL, 2'd3));
        apply_stimulus(ASC_ESC);

`ifdef KEYPAD_TIMEOUT_EN
        // Plain timeout after 20 idle cycles
        do_start(2'd2);
        apply_stimulus("5");
        repeat (19) @(negedge clk);
        check_output("to_pre_busy", 32'(bus.busy), 32'd1);
        exp_q.push_back(mk(ST_TIMEOUT, 2'd2));
        @(negedge clk);
        check_output("to_status", 32'(bus.status_code_out), 32'(ST_TIMEOUT));
        check_output("to_busy", 32'(bus.busy), 32'd0);
        read_check("to_f2", 2'd2, 16'h1234, 1'b1);

        // A key at idle cycle 19 restarts the inactivity window
        do_start(2'd2);
        apply_stimulus("5");
        repeat (18) @(negedge clk);
        apply_stimulus("6");
        repeat (19) @(negedge clk);
        check_output("to_delay_busy", 32'(bus.busy), 32'd1);
        check_output("to_delay_value", 32'(bus.cur_value), 32'h0056);
        exp_q.push_back(mk(ST_TIMEOUT, 2'd2));
        @(negedge clk);
        check_output("to_delay_status", 32'(bus.status_code_out), 32'(ST_TIMEOUT));
        read_check("to_delay_f2", 2'd2, 16'h1234, 1'b1);
`else
        // Without the timeout an entry stays open indefinitely
        do_start(2'd2);
        apply_stimulus("5");
        repeat (40) @(negedge clk);
        check_output("no_to_busy", 32'(bus.busy), 32'd1);
        check_output("no_to_status", 32'(bus.status_code_out), 32'(ST_OK));
        exp_q.push_back(mk(ST_CANCEL, 2'd2));
        apply_stimulus(ASC_ESC);
`endif

        // Asynchronous reset in the middle of an entry
        do_start(2'd1);
        type_str("12");
        #2;
        rst_n = 1'b0;
        #1;
        check_output("arst_busy", 32'(bus.busy), 32'd0);
        check_output("arst_len", 32'(bus.cur_len), 32'd0);
        check_output("arst_done", 32'(bus.done), 32'd0);
        for (int f = 0; f < 4; f++) read_check("arst_bank", 2'(f), 16'h0000, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        check_output("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/atm_keypad_entry.md
Name: atm_keypad_entry

Overview:
Parametrised ASCII keypad-entry collector for the CryptoATM front end. It accumulates decimal keystrokes into packed-BCD fields: account, password, destination account, amount, and so on. It supports backspace, cancel and min/max length checks. Each committed field is stored in an internal bank of NUM_FIELDS registers, one per field, which the ATM control FSM reads back. It sits between the keyboard/UART ASCII decoder and the ATM main state machine.

Parameters:
MAX_DIGITS, 4, maximum digits per field; VAL_W = 4*MAX_DIGITS.
MIN_DIGITS, 4, minimum digits accepted on Enter (1..MAX_DIGITS).
NUM_FIELDS, 4, number of stored fields; FS_W = clog2(NUM_FIELDS), minimum 1.
TIMEOUT_CYC, 1000000, inactivity limit in clk cycles; used only with the optional feature.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
start  in  1  one-cycle pulse; arms collection into field field_sel.
field_sel  in  FS_W  target field, sampled on start.
key_valid  in  1  one-cycle strobe; key_code is valid this cycle.
key_code  in  8  ASCII byte.
busy  out  1  high while collecting.
cur_len  out  clog2(MAX_DIGITS+1)  digits entered so far.
cur_value  out  VAL_W  live packed-BCD entry, right-justified (for display).
done  out  1  one-cycle pulse when an entry terminates.
status_code_out  out  4  result of the last entry or the last key error.
field_id_out  out  FS_W  field that the last done refers to.
rd_sel  in  FS_W  bank read select.
rd_value  out  VAL_W  stored value of field rd_sel (combinational read).
rd_valid  out  1  field rd_sel has been committed since reset.

Behaviour:
- Reset (async, rst_n=0):
  - state IDLE; all outputs 0; bank cleared; all valid bits 0; status_code_out = ST_OK (0).
- States:
  - IDLE: keys ignored; start -> COLLECT, clear cur_len/cur_value, latch field_sel.
  - COLLECT: busy=1; handles keys as below.
- Key handling in COLLECT (sampled on the clk edge; effect visible the next cycle):
  - Digit 0x30-0x39, cur_len<MAX_DIGITS: cur_value = {cur_value[VAL_W-5:0], key_code[3:0]}, cur_len++.
  - Digit at cur_len==MAX_DIGITS: ignored; status_code_out=ST_OVERFLOW(2); stay in COLLECT.
  - Backspace 0x08: cur_value >>= 4, cur_len--. At cur_len==0 it is a no-op with no error.
  - Enter 0x0D with cur_len>=MIN_DIGITS:
    - bank[field] <= cur_value; valid[field] <= 1.
    - status ST_OK(0); done pulse; -> IDLE.
  - Enter 0x0D with cur_len<MIN_DIGITS: status ST_TOO_SHORT(1); done pulse; no commit; -> IDLE.
  - Escape 0x1B: status ST_CANCEL(4); done pulse; no commit; -> IDLE.
  - Any other byte: ignored; status ST_BAD_CHAR(3); stay in COLLECT.
- Latency: done, status_code_out and field_id_out update one cycle after the terminating key is sampled. The bank write occurs on that same edge, so rd_value shows the new value in the cycle done is high.
- Priority within one cycle:
  - start in COLLECT restarts: clear, relatch field, no done pulse. Any key_valid in the same cycle is dropped.
  - start in IDLE with key_valid: start taken, key dropped.
- rd_sel >= NUM_FIELDS: rd_value=0, rd_valid=0.
- cur_value and cur_len hold their last values in IDLE until the next start.
- status_code_out is sticky until the next key error, termination or start (start clears it to ST_OK).
- Reset during COLLECT aborts with no done pulse and clears the bank.

Optional Feature:
Macro KEYPAD_TIMEOUT_EN.
- Defined:
  - A counter of clog2(TIMEOUT_CYC+1) bits clears on start and on every key_valid in COLLECT, and increments otherwise in COLLECT.
  - On reaching TIMEOUT_CYC: status ST_TIMEOUT(5); done pulse; no commit; -> IDLE.
  - A timeout and a key in the same cycle: the key wins, the counter clears.
- Not defined: no counter is synthesised; entry waits indefinitely; code 5 is never produced.

Decomposition:
- Shared package atm_input_pkg:
  - ASCII constants: ASC_0, ASC_9, ASC_CR, ASC_BS, ASC_ESC.
  - 4-bit status codes: ST_OK, ST_TOO_SHORT, ST_OVERFLOW, ST_BAD_CHAR, ST_CANCEL, ST_TIMEOUT.
  - State encoding: IDLE, COLLECT.
- One sub-module, atm_key_classify: combinational; maps key_code to a one-hot class {digit, enter, bksp, esc, other} plus a 4-bit digit value.
- Bank and FSM stay in the top module.

Test Plan:
- Digit entry and commit (defaults): start field 1; keys 0x30,0x32,0x37,0x34,0x0D.
  -> done one cycle after Enter; status 0; field_id_out=1; rd_sel=1 gives rd_value=16'h0274, rd_valid=1.
- Short entry, then backspace: start field 0; keys "027", Enter -> status 1, rd_valid[0]=0.
  Then start; keys "0275", BS, "4", Enter -> rd_value=16'h0274.
- Overflow and bad characters: keys "12345" -> cur_value=16'h1234, status 2.
  Then key 0x40 -> status 3, still busy; Enter -> status 0, stored 16'h1234.
- Cancel and restart: keys "99", ESC -> status 4, no commit, bank unchanged.
  start pulsed mid-entry with key_valid -> cur_len=0, no done, key dropped.
- Reset mid-entry: rst_n low asynchronously during COLLECT -> busy=0, rd_valid=0 for all fields, no done pulse.
- Timeout (KEYPAD_TIMEOUT_EN, TIMEOUT_CYC=20): start, key "5", idle 20 cycles -> done, status 5, no commit.
  A key arriving at cycle 19 delays the expiry.
